// File: rtl/adc_mov_sum_if.sv
// Sample stream, control and window-sum result bundle for adc_mov_sum.
// The master drives samples and control; the slave returns the window sum.
interface adc_mov_sum_if #(
  parameter int DATA_W = 10,
  parameter int SUM_W  = 32
);
  logic              clr;
  logic              start;
  logic [7:0]        window_size;
  logic              absolute_value;
  logic [DATA_W-1:0] adc_data;
  logic [SUM_W-1:0]  sum_out;
  logic              sum_val;

  modport master (
    output clr, start, window_size, absolute_value, adc_data,
    input  sum_out, sum_val
  );

  modport slave (
    input  clr, start, window_size, absolute_value, adc_data,
    output sum_out, sum_val
  );
endinterface

// File: rtl/adc_mov_sum.sv
// Moving-window sum of the last N conditioned ADC samples (raw or rectified
// about mid-scale), fed through a capture -> condition -> accumulate pipeline.
module adc_mov_sum #(
  parameter int DATA_W = 10,
  parameter int SUM_W  = 32,
  parameter int DEPTH  = 256
) (
  input logic          ADC_clk,
  input logic          reset_n,
  adc_mov_sum_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = DATA_W + 1;
  localparam int ACC_W = DATA_W + AW + 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] adcRaw_q;
  logic              absRaw_q;
  logic              inVld_q;
  logic [CW-1:0]     cond_q;
  logic              condVld_q;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              sumVal_q, sumVal_d;
  logic [7:0]        winN_q, winN_d;
  logic [7:0]        fill_q, fill_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [CW-1:0]     hist_q [DEPTH];

  logic          loadEn;
  logic          captureEn;
  logic          accEn;
  logic          subEn;
  logic [7:0]    fillInc;
  logic [CW-1:0] condVal;
  logic [AW-1:0] rdAddr;
  logic [AW:0]   wpExt;
  logic [AW:0]   winExt;
  logic [CW-1:0] outgoing;

  assign fillInc = fill_q + 8'd1;

  always_ff @(posedge ADC_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start) state_d = FILL;
        FILL: begin
          if (!bus.start) begin
            state_d = IDLE;
          end else if (accEn && (fillInc == winN_q)) begin
            state_d = RUN;
          end
        end
        RUN:  if (!bus.start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Samples are only accepted while active; leaving IDLE flushes the pipe.
  always_comb begin
    loadEn    = (state_q == IDLE) && bus.start;
    captureEn = (state_q != IDLE) && bus.start;
    accEn     = (state_q != IDLE) && condVld_q;
    subEn     = (state_q == RUN);
  end

  always_comb begin
    condVal = CW'(adcRaw_q);
    if (absRaw_q) begin
      if (adcRaw_q >= MID) begin
        condVal = CW'(adcRaw_q - MID);
      end else begin
        condVal = CW'(MID - adcRaw_q);
      end
    end
  end

  // Outgoing slot is wp-N modulo DEPTH; N < DEPTH keeps it off the write slot.
  always_comb begin
    wpExt  = {1'b0, wp_q};
    winExt = (AW+1)'(winN_q);
    if (wpExt >= winExt) begin
      rdAddr = AW'(wpExt - winExt);
    end else begin
      rdAddr = AW'(wpExt + (AW+1)'(DEPTH) - winExt);
    end
  end

  assign outgoing = hist_q[rdAddr];

  always_comb begin
    sum_d    = sum_q;
    sumVal_d = sumVal_q;
    winN_d   = winN_q;
    fill_d   = fill_q;
    wp_d     = wp_q;
    if (loadEn) begin
      winN_d   = (bus.window_size == 8'd0) ? 8'd1 : bus.window_size;
      sum_d    = '0;
      fill_d   = '0;
      sumVal_d = 1'b0;
    end else if (accEn) begin
      wp_d = (wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
      if (subEn) begin
        sum_d    = sum_q + ACC_W'(cond_q) - ACC_W'(outgoing);
        sumVal_d = 1'b1;
      end else begin
        sum_d    = sum_q + ACC_W'(cond_q);
        fill_d   = fillInc;
        sumVal_d = (fillInc == winN_q);
      end
    end else if (state_q == IDLE) begin
      sumVal_d = 1'b0;
    end
  end

  always_ff @(posedge ADC_clk or negedge reset_n) begin
    if (!reset_n) begin
      adcRaw_q  <= '0;
      absRaw_q  <= 1'b0;
      inVld_q   <= 1'b0;
      cond_q    <= '0;
      condVld_q <= 1'b0;
      sum_q     <= '0;
      sumVal_q  <= 1'b0;
      winN_q    <= '0;
      fill_q    <= '0;
      wp_q      <= '0;
    end else if (bus.clr) begin
      adcRaw_q  <= '0;
      absRaw_q  <= 1'b0;
      inVld_q   <= 1'b0;
      cond_q    <= '0;
      condVld_q <= 1'b0;
      sum_q     <= '0;
      sumVal_q  <= 1'b0;
      winN_q    <= '0;
      fill_q    <= '0;
      wp_q      <= '0;
    end else begin
      adcRaw_q  <= bus.adc_data;
      absRaw_q  <= bus.absolute_value;
      inVld_q   <= captureEn;
      cond_q    <= condVal;
      condVld_q <= inVld_q && (state_q != IDLE);
      sum_q     <= sum_d;
      sumVal_q  <= sumVal_d;
      winN_q    <= winN_d;
      fill_q    <= fill_d;
      wp_q      <= wp_d;
    end
  end

  always_ff @(posedge ADC_clk) begin
    if (accEn && !bus.clr) begin
      hist_q[wp_q] <= cond_q;
    end
  end

  assign bus.sum_out = SUM_W'(sum_q);
  assign bus.sum_val = sumVal_q;

endmodule

// File: tb/tb_adc_mov_sum.sv
// Directed bench for adc_mov_sum: a window-of-samples model checked every
// cycle, plus hand-computed sums at the interesting points of each scenario.
module tb_adc_mov_sum;

  localparam int DATA_W = 10;
  localparam int SUM_W  = 32;
  localparam int DEPTH  = 256;
  localparam int HIST   = 4096;

  logic clk = 1'b0;
  logic resetN;

  adc_mov_sum_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

  adc_mov_sum #(.DATA_W(DATA_W), .SUM_W(SUM_W), .DEPTH(DEPTH)) dut (
    .ADC_clk (clk),
    .reset_n (resetN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int    checks  = 0;
  int    errors  = 0;
  bit    checkEn = 1'b0;
  bit    litEn   = 1'b0;
  string litName = "";
  int    litSum  = 0;
  bit    litVal  = 1'b0;

  // Model: conditioned value of every edge's sample, and the current session.
  int cHist [HIST];
  int edgeNo      = 0;
  bit active      = 1'b0;
  bit haveSession = 1'b0;
  int sessS       = 0;
  int sessT       = 0;
  int sessN       = 1;
  int expSum      = 0;
  bit expVal      = 1'b0;

  function automatic int condOf(input int d, input bit ab);
    if (!ab) return d;
    return (d >= 512) ? d - 512 : 512 - d;
  endfunction

  task automatic modelStep();
    int eff;
    int hi;
    int lo;
    int acc;
    if (!resetN) begin
      active      = 1'b0;
      haveSession = 1'b0;
      expSum      = 0;
      expVal      = 1'b0;
    end else begin
      edgeNo++;
      cHist[edgeNo % HIST] = condOf(int'(bus.adc_data), bus.absolute_value);
      if (bus.clr) begin
        active      = 1'b0;
        haveSession = 1'b0;
        expSum      = 0;
        expVal      = 1'b0;
      end else begin
        if (!active && bus.start) begin
          active      = 1'b1;
          haveSession = 1'b1;
          sessS       = edgeNo;
          sessN       = (bus.window_size == 8'd0) ? 1 : int'(bus.window_size);
        end else if (active && !bus.start) begin
          active = 1'b0;
          sessT  = edgeNo;
        end
        if (haveSession) begin
          eff = active ? edgeNo : sessT;
          hi  = eff - 2;
          lo  = (hi - sessN + 1 > sessS + 1) ? hi - sessN + 1 : sessS + 1;
          acc = 0;
          for (int k = lo; k <= hi; k++) acc += cHist[k % HIST];
          expSum = acc;
          expVal = (edgeNo == eff) && (eff - sessS - 2 >= sessN);
        end
      end
    end
  endtask

  always begin
    @(posedge clk or negedge resetN);
    modelStep();
  end

  task automatic checkOutput();
    checks++;
    if (bus.sum_out !== SUM_W'(expSum)) begin
      errors++;
      $display("[TB] FAIL sum_out edge %0d: got %0d expected %0d", edgeNo, bus.sum_out, expSum);
    end
    checks++;
    if (bus.sum_val !== expVal) begin
      errors++;
      $display("[TB] FAIL sum_val edge %0d: got %0b expected %0b", edgeNo, bus.sum_val, expVal);
    end
    if (litEn) begin
      checks++;
      if (bus.sum_out !== SUM_W'(litSum)) begin
        errors++;
        $display("[TB] FAIL %s sum_out: got %0d expected %0d", litName, bus.sum_out, litSum);
      end
      checks++;
      if (bus.sum_val !== litVal) begin
        errors++;
        $display("[TB] FAIL %s sum_val: got %0b expected %0b", litName, bus.sum_val, litVal);
      end
      checks++;
      if (expSum != litSum || expVal != litVal) begin
        errors++;
        $display("[TB] FAIL %s model: got %0d/%0b expected %0d/%0b", litName, expSum, expVal, litSum, litVal);
      end
    end
  endtask

  always begin
    @(negedge clk);
    if (checkEn) checkOutput();
  end

  // Inputs change just after the compare point and are taken by the next edge.
  task automatic applyStimulus(input bit st, input bit cl, input int w, input bit ab, input int d);
    @(negedge clk);
    #1;
    litEn                = 1'b0;
    bus.start            = st;
    bus.clr              = cl;
    bus.window_size      = 8'(w);
    bus.absolute_value   = ab;
    bus.adc_data         = DATA_W'(d);
  endtask

  task automatic expectLit(input string name, input int s, input bit v);
    litName = name;
    litSum  = s;
    litVal  = v;
    litEn   = 1'b1;
  endtask

  // Reset lands between edges and is still held at the next compare point.
  task automatic pulseReset();
    @(negedge clk);
    #1;
    litEn = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b0;
    expectLit("async_reset", 0, 1'b0);
    @(negedge clk);
    #1;
    litEn     = 1'b0;
    resetN    = 1'b1;
    bus.start = 1'b0;
  endtask

  int absData [7] = '{512, 600, 400, 0, 0, 1023, 700};
  bit absSel  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    resetN             = 1'b0;
    bus.clr            = 1'b0;
    bus.start          = 1'b0;
    bus.window_size    = 8'd0;
    bus.absolute_value = 1'b0;
    bus.adc_data       = '0;
    #1;
    checkEn = 1'b1;
    expectLit("reset_state", 0, 1'b0);
    @(negedge clk);
    #1;
    litEn  = 1'b0;
    resetN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    expectLit("idle_after_reset", 0, 1'b0);

    $display("[TB] ramp, N=4 raw, window_size changed mid-run");
    applyStimulus(1, 0, 4, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1, 0, (i < 3) ? 4 : 9, 0, i);
      case (i)
        5: expectLit("ramp_fill", 6, 1'b0);
        6: expectLit("ramp_first", 10, 1'b1);
        7: expectLit("ramp_second", 14, 1'b1);
        8: expectLit("ramp_third", 18, 1'b1);
        default: ;
      endcase
    end
    applyStimulus(0, 0, 9, 0, 11);
    applyStimulus(0, 0, 9, 0, 12);
    expectLit("ramp_stop", 30, 1'b0);
    applyStimulus(0, 0, 9, 0, 13);
    expectLit("ramp_frozen", 30, 1'b0);
    applyStimulus(0, 1, 0, 0, 0);
    expectLit("idle_clr", 0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] rectified samples, N=3");
    applyStimulus(1, 0, 3, 1, 100);
    for (int j = 1; j <= 7; j++) begin
      applyStimulus(1, 0, 3, absSel[j-1], absData[j-1]);
      if (j == 5) expectLit("abs_first", 200, 1'b1);
      if (j == 6) expectLit("abs_second", 712, 1'b1);
    end
    applyStimulus(0, 0, 3, 0, 0);
    applyStimulus(0, 0, 3, 0, 0);

    $display("[TB] window_size 0 acts as 1");
    applyStimulus(1, 0, 0, 0, 7);
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(1, 0, 0, 0, 7);
      if (j == 2) expectLit("n0_before", 0, 1'b0);
      if (j == 3) expectLit("n0_first", 7, 1'b1);
      if (j == 5) expectLit("n0_steady", 7, 1'b1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] N=255 full-scale, pointer wrap");
    applyStimulus(1, 0, 255, 0, 1023);
    for (int j = 1; j <= 300; j++) begin
      applyStimulus(1, 0, 255, 0, 1023);
      if (j == 256) expectLit("n255_fill", 259842, 1'b0);
      if (j == 257) expectLit("n255_full", 260865, 1'b1);
      if (j == 300) expectLit("n255_held", 260865, 1'b1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] N=8 drop, then restart with N=2");
    applyStimulus(1, 0, 8, 0, 0);
    for (int j = 1; j <= 15; j++) applyStimulus(1, 0, 8, 0, 50 * j);
    applyStimulus(0, 0, 8, 0, 0);
    applyStimulus(0, 0, 8, 0, 0);
    expectLit("drop_frozen", 4200, 1'b0);
    applyStimulus(1, 0, 2, 0, 5);
    expectLit("restart_zero", 0, 1'b0);
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(1, 0, 2, 0, 5);
      if (j == 3) expectLit("restart_fill", 5, 1'b0);
      if (j == 4) expectLit("restart_first", 10, 1'b1);
      if (j == 5) expectLit("restart_steady", 10, 1'b1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] clr together with start while running");
    applyStimulus(1, 0, 3, 0, 9);
    for (int j = 1; j <= 6; j++) applyStimulus(1, 0, 3, 0, 9);
    applyStimulus(1, 1, 3, 0, 9);
    expectLit("clr_with_start", 0, 1'b0);
    applyStimulus(1, 0, 3, 0, 9);
    expectLit("after_clr_load", 0, 1'b0);
    for (int j = 1; j <= 6; j++) applyStimulus(1, 0, 3, 0, 9);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] asynchronous reset while running");
    applyStimulus(1, 0, 4, 0, 20);
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1, 0, 4, 0, 20);
      if (j == 8) expectLit("pre_reset_run", 80, 1'b1);
    end
    pulseReset();
    applyStimulus(0, 0, 0, 0, 0);
    expectLit("post_reset_idle", 0, 1'b0);
    applyStimulus(1, 0, 2, 0, 3);
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(1, 0, 2, 0, 3);
      if (j == 4) expectLit("post_reset_run", 6, 1'b1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
